// File: rtl/proc_pkg.sv
// Shared encodings for the 16-bit, 8-register processor: opcodes, pipe FSM states and
// operand-forwarding selects.
package proc_pkg;

  localparam logic [4:0] OpLd  = 5'b10000;
  localparam logic [4:0] OpSt  = 5'b10010;
  localparam logic [4:0] OpLl  = 5'b01000;
  localparam logic [4:0] OpLh  = 5'b01001;
  localparam logic [4:0] OpHlt = 5'b11111;

  // r7 is written through a side path, so writes to it never need forwarding.
  localparam logic [2:0] SideReg = 3'd7;

  typedef enum logic [2:0] {
    StRun,
    StLdStall,
    StMemWait,
    StFlush,
    StDrain,
    StHalted
  } pipe_state_t;

  typedef enum logic [1:0] {
    FwdRf  = 2'b00,
    FwdEx  = 2'b01,
    FwdMem = 2'b10
  } fwd_sel_t;

  function automatic fwd_sel_t fwd_pick(input logic [2:0] src, input logic ex_ok,
                                        input logic [2:0] ex_rd, input logic mem_ok,
                                        input logic [2:0] mem_rd);
    if (ex_ok && (src == ex_rd)) return FwdEx;
    if (mem_ok && (src == mem_rd)) return FwdMem;
    return FwdRf;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Decode-side fields in, pipeline control and forwarding selects out.
interface pipe_ctrl_if;
  import proc_pkg::*;

  logic       dec_valid;
  logic [4:0] dec_opcode;
  logic [2:0] dec_rs1;
  logic [2:0] dec_rs2;
  logic [2:0] dec_rd;
  logic       dec_wren;
  logic       dec_ren_mem;
  logic       dec_wren_mem;
  logic       dec_hlt;
  logic       ex_branch_taken;
  logic       mem_ready;

  logic       stall_fd;
  logic       bubble_ex;
  logic       flush_fd;
  logic       freeze;
  fwd_sel_t   fwd1_sel;
  fwd_sel_t   fwd2_sel;
  logic       halted;

  modport master (
    output dec_valid, dec_opcode, dec_rs1, dec_rs2, dec_rd, dec_wren, dec_ren_mem,
           dec_wren_mem, dec_hlt, ex_branch_taken, mem_ready,
    input  stall_fd, bubble_ex, flush_fd, freeze, fwd1_sel, fwd2_sel, halted
  );

  modport slave (
    input  dec_valid, dec_opcode, dec_rs1, dec_rs2, dec_rd, dec_wren, dec_ren_mem,
           dec_wren_mem, dec_hlt, ex_branch_taken, mem_ready,
    output stall_fd, bubble_ex, flush_fd, freeze, fwd1_sel, fwd2_sel, halted
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks the destinations of the instructions in EX and MEM and derives the forwarding
// selects and the load-use hazard from them.
module hazard_scoreboard
  import proc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance_i,
  input  logic       insert_i,
  input  logic       dec_valid_i,
  input  logic [2:0] dec_rs1_i,
  input  logic [2:0] dec_rs2_i,
  input  logic [2:0] dec_rd_i,
  input  logic       dec_wren_i,
  input  logic       dec_ren_mem_i,
  input  logic       dec_wren_mem_i,
  output fwd_sel_t   fwd1_sel_o,
  output fwd_sel_t   fwd2_sel_o,
  output logic       load_use_o,
  output logic       ex_v_o,
  output logic       mem_v_o,
  output logic       mem_memop_o
);

  logic       ex_v_q, ex_v_d, ex_wr_q, ex_wr_d, ex_ld_q, ex_ld_d, ex_memop_q, ex_memop_d;
  logic [2:0] ex_rd_q, ex_rd_d, mem_rd_q;
  logic       mem_v_q, mem_wr_q, mem_memop_q;
  logic       ex_fwd_ok, mem_fwd_ok;

  always_comb begin
    ex_v_d     = dec_valid_i & insert_i;
    ex_rd_d    = dec_rd_i;
    ex_wr_d    = dec_wren_i & (dec_rd_i != SideReg);
    ex_ld_d    = dec_ren_mem_i;
    ex_memop_d = dec_ren_mem_i | dec_wren_mem_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q      <= 1'b0;
      ex_rd_q     <= 3'd0;
      ex_wr_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      ex_memop_q  <= 1'b0;
      mem_v_q     <= 1'b0;
      mem_rd_q    <= 3'd0;
      mem_wr_q    <= 1'b0;
      mem_memop_q <= 1'b0;
    end else if (advance_i) begin
      mem_v_q     <= ex_v_q;
      mem_rd_q    <= ex_rd_q;
      mem_wr_q    <= ex_wr_q;
      mem_memop_q <= ex_memop_q;
      ex_v_q      <= ex_v_d;
      ex_rd_q     <= ex_rd_d;
      ex_wr_q     <= ex_wr_d;
      ex_ld_q     <= ex_ld_d;
      ex_memop_q  <= ex_memop_d;
    end
  end

  // A load in EX has no result yet; its consumer must wait for the MEM path.
  assign ex_fwd_ok  = ex_v_q & ex_wr_q & ~ex_ld_q;
  assign mem_fwd_ok = mem_v_q & mem_wr_q;

  assign fwd1_sel_o  = fwd_pick(dec_rs1_i, ex_fwd_ok, ex_rd_q, mem_fwd_ok, mem_rd_q);
  assign fwd2_sel_o  = fwd_pick(dec_rs2_i, ex_fwd_ok, ex_rd_q, mem_fwd_ok, mem_rd_q);
  assign load_use_o  = dec_valid_i & ex_v_q & ex_ld_q &
                       ((dec_rs1_i == ex_rd_q) | (dec_rs2_i == ex_rd_q));
  assign ex_v_o      = ex_v_q;
  assign mem_v_o     = mem_v_q;
  assign mem_memop_o = mem_memop_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall/bubble/flush/freeze control, forwarding selects and halt
// sequencing beside the decode stage.
module pipe_ctrl
  import proc_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.slave bus
);

  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);

  pipe_state_t state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        stall_fd, bubble_ex, flush_fd, freeze, halted;
  logic        load_use, ex_v, mem_v, mem_memop, mem_wait;

  hazard_scoreboard u_scoreboard (
    .clk            (clk),
    .rst_n          (rst_n),
    .advance_i      (~freeze),
    .insert_i       (~(bubble_ex | flush_fd | stall_fd)),
    .dec_valid_i    (bus.dec_valid),
    .dec_rs1_i      (bus.dec_rs1),
    .dec_rs2_i      (bus.dec_rs2),
    .dec_rd_i       (bus.dec_rd),
    .dec_wren_i     (bus.dec_wren),
    .dec_ren_mem_i  (bus.dec_ren_mem),
    .dec_wren_mem_i (bus.dec_wren_mem),
    .fwd1_sel_o     (bus.fwd1_sel),
    .fwd2_sel_o     (bus.fwd2_sel),
    .load_use_o     (load_use),
    .ex_v_o         (ex_v),
    .mem_v_o        (mem_v),
    .mem_memop_o    (mem_memop)
  );

  assign mem_wait = mem_v & mem_memop & ~bus.mem_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_fd  = 1'b0;
    bubble_ex = 1'b0;
    flush_fd  = 1'b0;
    freeze    = 1'b0;
    halted    = 1'b0;
    unique case (state_q)
      StRun, StLdStall, StDrain: begin
        if (mem_wait) begin
          freeze  = 1'b1;
          state_d = StMemWait;
        end else if (bus.ex_branch_taken) begin
          flush_fd  = 1'b1;
          bubble_ex = 1'b1;
          cnt_d     = FlushLoad;
          state_d   = (FlushLoad == 3'd0) ? StRun : StFlush;
        end else if ((bus.dec_valid && bus.dec_hlt) || (state_q == StDrain)) begin
          stall_fd  = 1'b1;
          bubble_ex = 1'b1;
          state_d   = ((state_q == StDrain) && !ex_v && !mem_v) ? StHalted : StDrain;
        end else if (load_use) begin
          stall_fd  = 1'b1;
          bubble_ex = 1'b1;
          state_d   = StLdStall;
        end else begin
          state_d = StRun;
        end
      end
      StMemWait: begin
        if (bus.mem_ready) begin
          state_d = StRun;
          // The frozen decode/EX pair may still form a load-use hazard.
          if (load_use) begin
            stall_fd  = 1'b1;
            bubble_ex = 1'b1;
          end
        end else begin
          freeze = 1'b1;
        end
      end
      StFlush: begin
        flush_fd  = 1'b1;
        bubble_ex = 1'b1;
        cnt_d     = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = StRun;
      end
      StHalted: begin
        halted    = 1'b1;
        stall_fd  = 1'b1;
        bubble_ex = 1'b1;
      end
      default: state_d = StRun;
    endcase
    // Controls read as idle for as long as reset is held.
    if (!rst_n) begin
      stall_fd  = 1'b0;
      bubble_ex = 1'b0;
      flush_fd  = 1'b0;
      freeze    = 1'b0;
      halted    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall_fd  = stall_fd;
  assign bus.bubble_ex = bubble_ex;
  assign bus.flush_fd  = flush_fd;
  assign bus.freeze    = freeze;
  assign bus.halted    = halted;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected control vectors are queued per cycle and checked
// by an independent monitor on the falling edge.
module tb_pipe_ctrl;
  import proc_pkg::*;

  localparam logic [4:0] OpAdd = 5'b00000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_ctrl_if if1 ();
  pipe_ctrl_if if2 ();

  pipe_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  pipe_ctrl #(.FLUSH_CYCLES(1)) dut_f1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2.slave)
  );

  typedef struct {
    bit         which;
    string      name;
    logic [8:0] exp;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [8:0] got;

  // {stall, bubble, flush, freeze, halted, fwd1[1:0], fwd2[1:0]}
  function automatic logic [8:0] pk(input logic s, input logic b, input logic fl,
                                    input logic fr, input logic h, input logic [1:0] f1,
                                    input logic [1:0] f2);
    return {s, b, fl, fr, h, f1, f2};
  endfunction

  function automatic logic [8:0] sample(input bit which);
    if (which)
      return {if2.stall_fd, if2.bubble_ex, if2.flush_fd, if2.freeze, if2.halted,
              if2.fwd1_sel, if2.fwd2_sel};
    return {if1.stall_fd, if1.bubble_ex, if1.flush_fd, if1.freeze, if1.halted,
            if1.fwd1_sel, if1.fwd2_sel};
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      e   = q.pop_front();
      got = sample(e.which);
      n_checks++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b want %b (s,b,fl,fr,h,f1,f2)", e.name, got, e.exp);
      end
    end
  end

  task automatic push(input string nm, input logic [8:0] ex, input bit which);
    exp_t t;
    t.which = which;
    t.name  = nm;
    t.exp   = ex;
    q.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string nm, input logic [8:0] ex);
    push(nm, ex, 1'b0);
    tick();
  endtask

  task automatic d1(input logic v, input logic [4:0] op, input logic [2:0] rs1,
                    input logic [2:0] rs2, input logic [2:0] rd, input logic wr,
                    input logic ld, input logic st, input logic hlt);
    if1.dec_valid    = v;
    if1.dec_opcode   = op;
    if1.dec_rs1      = rs1;
    if1.dec_rs2      = rs2;
    if1.dec_rd       = rd;
    if1.dec_wren     = wr;
    if1.dec_ren_mem  = ld;
    if1.dec_wren_mem = st;
    if1.dec_hlt      = hlt;
  endtask

  task automatic idle1();
    d1(1'b0, OpAdd, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] z, sb, fb, frz;
    z   = pk(0, 0, 0, 0, 0, 2'b00, 2'b00);
    sb  = pk(1, 1, 0, 0, 0, 2'b00, 2'b00);
    fb  = pk(0, 0, 1, 0, 0, 2'b00, 2'b00);
    fb[7] = 1'b1;
    frz = pk(0, 0, 0, 1, 0, 2'b00, 2'b00);

    rst_n = 1'b0;
    idle1();
    if1.ex_branch_taken = 1'b0;
    if1.mem_ready       = 1'b1;
    if2.dec_valid = 1'b0; if2.dec_opcode = OpAdd; if2.dec_rs1 = 3'd0; if2.dec_rs2 = 3'd0;
    if2.dec_rd = 3'd0; if2.dec_wren = 1'b0; if2.dec_ren_mem = 1'b0; if2.dec_wren_mem = 1'b0;
    if2.dec_hlt = 1'b0; if2.ex_branch_taken = 1'b0; if2.mem_ready = 1'b1;
    #1;
    cyc("reset_state", z);
    rst_n = 1'b1;

    // Load-use: LD r2, then ADD r3,r2,r1
    d1(1, OpLd, 3'd0, 3'd0, 3'd2, 1, 1, 0, 0);  cyc("ld_issue", z);
    d1(1, OpAdd, 3'd2, 3'd1, 3'd3, 1, 0, 0, 0); cyc("ld_use_stall", sb);
    cyc("ld_use_fwd_mem", pk(0, 0, 0, 0, 0, 2'b10, 2'b00));
    idle1();                                     cyc("ld_use_back_run", z);
    cyc("idle_a", z);

    // Forward priority and r7 exclusion
    d1(1, OpAdd, 3'd0, 3'd0, 3'd4, 1, 0, 0, 0);  cyc("fwd_w4_a", z);
    d1(1, OpAdd, 3'd0, 3'd0, 3'd4, 1, 0, 0, 0);  cyc("fwd_w4_b", z);
    d1(1, OpAdd, 3'd4, 3'd4, 3'd1, 1, 0, 0, 0);  cyc("fwd_ex_over_mem", pk(0, 0, 0, 0, 0, 2'b01, 2'b01));
    d1(1, OpAdd, 3'd4, 3'd1, 3'd0, 0, 0, 0, 0);  cyc("fwd_mem_and_ex", pk(0, 0, 0, 0, 0, 2'b10, 2'b01));
    d1(1, OpLl, 3'd0, 3'd0, 3'd7, 1, 0, 0, 0);   cyc("ll_r7_issue", z);
    d1(1, OpAdd, 3'd7, 3'd7, 3'd0, 0, 0, 0, 0);  cyc("r7_ex_no_fwd", z);
    d1(1, OpAdd, 3'd7, 3'd0, 3'd0, 0, 0, 0, 0);  cyc("r7_mem_no_fwd", z);
    idle1(); cyc("idle_b", z); cyc("idle_c", z);

    // Branch with FLUSH_CYCLES = 2, overriding a younger HLT
    d1(1, OpHlt, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1);
    if1.ex_branch_taken = 1'b1;                  cyc("br2_flush_0", fb);
    if1.ex_branch_taken = 1'b0; idle1();         cyc("br2_flush_1", fb);
    cyc("br2_back_run", z);

    // Branch with FLUSH_CYCLES = 1
    if2.ex_branch_taken = 1'b1; push("br1_flush_0", fb, 1'b1); tick();
    if2.ex_branch_taken = 1'b0; push("br1_back_run", z, 1'b1); tick();

    // Memory wait: ST in MEM, ADD r5 in EX, consumer of r5 in decode
    d1(1, OpSt, 3'd0, 3'd0, 3'd0, 0, 0, 1, 0);   cyc("st_issue", z);
    d1(1, OpAdd, 3'd0, 3'd0, 3'd5, 1, 0, 0, 0);  cyc("add_r5_issue", z);
    d1(1, OpAdd, 3'd5, 3'd0, 3'd6, 1, 0, 0, 0);
    if1.mem_ready = 1'b0;                        cyc("memwait_0", frz | pk(0, 0, 0, 0, 0, 2'b01, 2'b00));
    if1.ex_branch_taken = 1'b1;                  cyc("memwait_1_br_ignored", frz | pk(0, 0, 0, 0, 0, 2'b01, 2'b00));
    if1.ex_branch_taken = 1'b0;                  cyc("memwait_2", frz | pk(0, 0, 0, 0, 0, 2'b01, 2'b00));
    if1.mem_ready = 1'b1;                        cyc("memwait_release", pk(0, 0, 0, 0, 0, 2'b01, 2'b00));
    d1(1, OpAdd, 3'd5, 3'd0, 3'd0, 0, 0, 0, 0);  cyc("memwait_advanced", pk(0, 0, 0, 0, 0, 2'b10, 2'b00));
    idle1(); cyc("idle_d", z); cyc("idle_e", z);

    // Halt with two older instructions in flight
    d1(1, OpAdd, 3'd0, 3'd0, 3'd1, 1, 0, 0, 0);  cyc("hlt_old1", z);
    d1(1, OpAdd, 3'd0, 3'd0, 3'd2, 1, 0, 0, 0);  cyc("hlt_old2", z);
    d1(1, OpHlt, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1);  cyc("hlt_run", sb);
    cyc("hlt_drain_0", sb);
    cyc("hlt_drain_1", sb);
    cyc("halted_0", pk(1, 1, 0, 0, 1, 2'b00, 2'b00));
    if1.ex_branch_taken = 1'b1;                  cyc("halted_hold", pk(1, 1, 0, 0, 1, 2'b00, 2'b00));
    if1.ex_branch_taken = 1'b0;
    rst_n = 1'b0;                                cyc("reset_in_halted", z);
    rst_n = 1'b1; idle1();                       cyc("after_halt_reset_run", z);

    // Branch taken during DRAIN preempts the halt
    d1(1, OpAdd, 3'd0, 3'd0, 3'd1, 1, 0, 0, 0);  cyc("drain_br_old", z);
    d1(1, OpHlt, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1);  cyc("drain_br_hlt", sb);
    if1.ex_branch_taken = 1'b1;                  cyc("drain_br_flush_0", fb);
    if1.ex_branch_taken = 1'b0; idle1();         cyc("drain_br_flush_1", fb);
    cyc("drain_br_not_halted", z);

    // Reset while in MEMWAIT
    d1(1, OpSt, 3'd0, 3'd0, 3'd0, 0, 0, 1, 0);   cyc("rst_st_issue", z);
    idle1();                                     cyc("rst_st_ex", z);
    if1.mem_ready = 1'b0;                        cyc("rst_memwait_0", frz);
    cyc("rst_memwait_1", frz);
    rst_n = 1'b0;                                cyc("reset_in_memwait", z);
    rst_n = 1'b1; if1.mem_ready = 1'b1;          cyc("after_memwait_reset", z);
    if1.mem_ready = 1'b0;                        cyc("scoreboard_empty", z);
    if1.mem_ready = 1'b1;

    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencer for the 16-bit, 8-register processor. It sits beside the decode stage and consumes decode's opcode, register, write-enable, memory and branch fields. It tracks destination registers in flight in EX and MEM and drives stall, bubble, flush and freeze controls plus operand-forwarding selects. It also sequences halt by draining the pipe and then parking in a halted state.

## Interface
- `FLUSH_CYCLES`, default 2: number of cycles `flush_fd` is asserted per taken branch; legal values are 1 to 7.
- `clk` in 1: the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `dec_valid` in 1: the decode stage holds a real instruction.
- `dec_opcode` in 5: instruction [15:11].
- `dec_rs1`, `dec_rs2` in 3 each: decode read-register numbers.
- `dec_rd` in 3: decode destination register.
- `dec_wren` in 1: decoded instruction writes `dec_rd`.
- `dec_ren_mem` in 1: decoded instruction is LD.
- `dec_wren_mem` in 1: decoded instruction is ST.
- `dec_hlt` in 1: decoded instruction is HLT.
- `ex_branch_taken` in 1: the branch in EX resolved taken this cycle.
- `mem_ready` in 1: data memory completes the LD/ST in MEM this cycle.
- `stall_fd` out 1: hold PC and the fetch/decode registers.
- `bubble_ex` out 1: load a NOP into EX.
- `flush_fd` out 1: squash the fetch/decode contents.
- `freeze` out 1: hold every stage, including EX and MEM.
- `fwd1_sel`, `fwd2_sel` out 2 each: operand source; 00 = RF, 01 = EX result, 10 = MEM result.
- `halted` out 1: the processor is stopped.

## Operation
- Scoreboard registers: `ex_v`, `ex_rd`, `ex_wr`, `ex_ld`, `mem_v`, `mem_rd`, `mem_wr`, `mem_memop`.
  - A write to r7 counts as no write (`*_wr` = 0), because r7 is set through the side path.
- Scoreboard advance happens on every cycle with `freeze` = 0.
  - MEM takes the contents of EX.
  - EX takes the decode fields, but is empty if `dec_valid` = 0 or any of `bubble_ex`, `flush_fd` or `stall_fd` is 1.
  - With `freeze` = 1 the scoreboard holds.
- Forwarding select, per operand, in priority order:
  - 01 if the source matches `ex_rd` and `ex_v & ex_wr & !ex_ld`.
  - Otherwise 10 if it matches `mem_rd` and `mem_v & mem_wr`.
  - Otherwise 00.
  - Forwarding is computed in every state.
- Load-use hazard: `dec_valid`, `ex_v` and `ex_ld` are all set, and `dec_rs1` or `dec_rs2` equals `ex_rd`.
- States: RUN, LDSTALL, MEMWAIT, FLUSH, DRAIN, HALTED. The event priority below applies in RUN, LDSTALL and DRAIN.
  1. `mem_v & mem_memop & !mem_ready`: assert `freeze` and go to MEMWAIT. Branch and hazard inputs are ignored that cycle.
  2. `ex_branch_taken`: assert `flush_fd` and `bubble_ex`, load the counter with `FLUSH_CYCLES`-1, and go to FLUSH (or RUN if the counter is 0). The branch overrides a younger HLT or load-use hazard.
  3. `dec_valid & dec_hlt`: assert `stall_fd` and `bubble_ex`, and go to DRAIN.
  4. Load-use hazard: assert `stall_fd` and `bubble_ex`, and go to LDSTALL.
- LDSTALL: exactly one stall cycle has already been spent. Re-evaluate the priority list as in RUN; the hazard is now clear because the load has moved to MEM.
- MEMWAIT: keep `freeze` = 1 until `mem_ready` = 1. That cycle `freeze` = 0, and the next state is RUN.
- FLUSH: assert `flush_fd` and `bubble_ex`, and decrement the counter. Leave to RUN when the counter is 0. A taken branch in FLUSH cannot occur, because EX holds bubbles.
- DRAIN: assert `stall_fd` and `bubble_ex`.
  - If `!ex_v & !mem_v`, go to HALTED.
  - `ex_branch_taken` or a MEM wait preempts DRAIN per the priority list; the HLT was on the wrong path.
- HALTED: `halted`, `stall_fd` and `bubble_ex` are 1. The state is left only through reset.

## Timing
- State and counter are registered; the control outputs are combinational from state, scoreboard and inputs.
- Reset (asynchronous) forces:
  - state = RUN, counter = 0, all `*_v` = 0;
  - `stall_fd`, `bubble_ex`, `flush_fd`, `freeze` and `halted` = 0;
  - `fwd*_sel` = 00.
- Reset mid-operation, from any state, returns to RUN with an empty scoreboard in the same cycle.
- Load-use costs exactly 1 bubble.
- A taken branch costs `FLUSH_CYCLES` flush cycles, starting the same cycle `ex_branch_taken` is high.
- HLT to `halted`: at most 3 cycles (1 cycle in RUN plus up to 2 drain cycles).
- A memory wait adds one cycle per low `mem_ready` cycle, with zero overhead when `mem_ready` is 1 on first presentation.

## Structure
- `proc_pkg` holds:
  - the opcode localparams (LD 10000, ST 10010, LL 01000, LH 01001, HLT 11111);
  - the state enum `pipe_state_t`;
  - the forwarding-select enum `fwd_sel_t`.
- One sub-module, `hazard_scoreboard`: the EX/MEM tracking registers plus the forwarding and load-use comparators. The FSM stays in `pipe_ctrl`.

## Test plan
- Load-use: LD r2 in EX, then ADD r3,r2,r1 in decode → one cycle of `stall_fd` = `bubble_ex` = 1, LDSTALL, then RUN; the next cycle `fwd1_sel` = 10.
- Forward priority: r4 written in both EX and MEM, consumer reads r4 → `fwd1_sel` = 01. Reading r7 with an LL r7 in EX → 00.
- Branch: `ex_branch_taken` pulse in RUN with `FLUSH_CYCLES` = 2 → `flush_fd` high for exactly 2 cycles, then RUN. Repeat with `FLUSH_CYCLES` = 1 → 1 cycle.
- Memory wait: ST in MEM, `mem_ready` low for 3 cycles → `freeze` high for 3 cycles with the scoreboard unchanged, then RUN; a simultaneous `ex_branch_taken` during the wait is ignored.
- Halt: HLT decoded with 2 older instructions in flight → DRAIN for 2 cycles, then `halted` = 1 held; a branch taken during DRAIN → FLUSH instead, `halted` stays 0.
- Reset: assert `rst_n` = 0 in MEMWAIT and in HALTED → all outputs 0 immediately; after release, the state is RUN.
